// File: rtl/axis_pkg.sv
// Shared definitions for the AXI4-Stream sink endpoint.
package axis_pkg;

  localparam int unsigned AXIS_DATA_W = 8;
  localparam int unsigned AXIS_DEST_W = 5;
  localparam int unsigned CNT_W       = 16;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACCEPT = 2'b01;
  localparam logic [1:0] ST_REJECT = 2'b10;

  typedef enum logic [1:0] {
    StIdle   = ST_IDLE,
    StAccept = ST_ACCEPT,
    StReject = ST_REJECT
  } sink_state_e;

  // Saturating increment: sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
module axis_sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             wr_ok, rd_ok;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  // Zero when empty so the data lines read 0 out of reset.
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    wr_ok    = wr_en_i & ~full_o;
    rd_ok    = rd_en_i & ~empty_o;
    wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (wr_ok && !rd_ok) begin
      level_d = level_q + (AW+1)'(1);
    end else if (rd_ok && !wr_ok) begin
      level_d = level_q - (AW+1)'(1);
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/axis_dest_sink_fifo.sv
// AXI4-Stream sink: claims packets addressed to MY_DEST, buffers them in a FWFT FIFO and
// re-presents them downstream; non-matching packets are stalled or discarded whole.
module axis_dest_sink_fifo
  import axis_pkg::*;
#(
  parameter int unsigned DATA_W        = AXIS_DATA_W,
  parameter int unsigned DEST_W        = AXIS_DEST_W,
  parameter int unsigned MY_DEST       = 1,
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned DROP_MISMATCH = 0
) (
  input  logic                     i_sclk,
  input  logic                     i_srst,
  input  logic                     i_s_tvalid,
  input  logic [DEST_W-1:0]        i_s_tdest,
  input  logic [DATA_W-1:0]        i_s_tdata,
  input  logic                     i_s_tlast,
  output logic                     o_s_tready,
  output logic                     o_m_tvalid,
  output logic [DATA_W-1:0]        o_m_tdata,
  output logic                     o_m_tlast,
  input  logic                     i_m_tready,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [CNT_W-1:0]         o_pkt_count,
  output logic [CNT_W-1:0]         o_drop_count,
  output logic                     o_err_dest
);

  localparam logic [DEST_W-1:0] MyDestId = DEST_W'(MY_DEST);
  localparam bit                DropEn   = (DROP_MISMATCH != 0);

  sink_state_e      state_q, state_d;
  logic             match, up_hs, dn_hs;
  logic             wr_en, drop, err_set;
  logic             fifo_full, fifo_empty;
  logic [DATA_W:0]  fifo_dout;
  logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;
  logic             err_dest_q, err_dest_d;

  assign match = (i_s_tdest == MyDestId);
  assign up_hs = i_s_tvalid & o_s_tready;
  assign dn_hs = o_m_tvalid & i_m_tready;

  assign o_m_tvalid             = ~fifo_empty;
  assign {o_m_tlast, o_m_tdata} = fifo_dout;
  assign o_pkt_count            = pkt_count_q;
  assign o_drop_count           = drop_count_q;
  assign o_err_dest             = err_dest_q;

  // Upstream ready; depends on tdest only between packets.
  always_comb begin
    o_s_tready = 1'b0;
    if (!i_srst) begin
      unique case (state_q)
        StIdle:   o_s_tready = ~fifo_full & (match | DropEn);
        StAccept: o_s_tready = ~fifo_full;
        StReject: o_s_tready = 1'b1;
        default:  o_s_tready = 1'b0;
      endcase
    end
  end

  // Packet FSM next state and per-beat write/drop decisions.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    drop    = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (up_hs) begin
          if (match) begin
            wr_en = 1'b1;
            if (!i_s_tlast) state_d = StAccept;
          end else begin
            drop = 1'b1;
            if (!i_s_tlast) state_d = StReject;
          end
        end
      end
      StAccept: begin
        if (up_hs) begin
          wr_en   = 1'b1;
          err_set = ~match;
          if (i_s_tlast) state_d = StIdle;
        end
      end
      StReject: begin
        if (up_hs) begin
          drop = 1'b1;
          if (i_s_tlast) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Status counters and sticky destination error.
  always_comb begin
    pkt_count_d  = sat_inc(pkt_count_q, dn_hs & o_m_tlast);
    drop_count_d = sat_inc(drop_count_q, drop);
    err_dest_d   = err_dest_q | err_set;
  end

  // FSM and status state.
  always_ff @(posedge i_sclk) begin
    if (i_srst) begin
      state_q      <= StIdle;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
      err_dest_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
      err_dest_q   <= err_dest_d;
    end
  end

  axis_sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (i_sclk),
    .rst_i   (i_srst),
    .wr_en_i (wr_en),
    .din_i   ({i_s_tlast, i_s_tdata}),
    .rd_en_i (dn_hs),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (o_level)
  );

endmodule
